// File: rtl/mem_byte_reader.sv
// Byte-serial readout of a captured parallel word over a valid/ready handshake.
// Each emitted byte carries its byte index, so the outputs can load a byte-addressed MEM register directly.
module mem_byte_reader #(
   parameter int NUM_BYTES = 4,
   parameter bit MSB_FIRST = 1'b0,
   localparam int WORD_W   = NUM_BYTES * 8,
   localparam int IDX_W    = $clog2(NUM_BYTES)
) (
   input  logic              clk,
   input  logic              rst_RD,
   input  logic              RD_START,
   input  logic [WORD_W-1:0] RD_WORD,
   input  logic              RD_READY,
   output logic [7:0]        RD_OUT,
   output logic [IDX_W-1:0]  RD_BYTE_IDX,
   output logic              RD_VALID,
   output logic              RD_BUSY,
   output logic              RD_DONE,
   output logic [1:0]        dbg_state
);

   // Handshake: a byte moves when RD_VALID and RD_READY are both high at a rising edge;
   // while RD_VALID is high and RD_READY is low, RD_OUT/RD_BYTE_IDX/RD_VALID hold.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [IDX_W-1:0] FIRST_IDX = MSB_FIRST ? IDX_W'(NUM_BYTES - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : IDX_W'(NUM_BYTES - 1);
   localparam int               FIRST_LSB = (MSB_FIRST ? NUM_BYTES - 1 : 0) * 8;

   logic [1:0]        state;
   logic [WORD_W-1:0] shadow;
   logic [IDX_W-1:0]  idx;
   logic [7:0]        out_q;
   logic [IDX_W-1:0]  next_idx;
   logic [7:0]        next_byte;

   always_comb begin
      next_idx  = MSB_FIRST ? idx - IDX_W'(1) : idx + IDX_W'(1);
      next_byte = shadow[{next_idx, 3'b000} +: 8];
   end

   // idx and out_q are forced to zero outside SEND so the outputs read 0 when not valid.
   always_ff @(posedge clk) begin
      if (rst_RD) begin
         state  <= ST_IDLE;
         shadow <= '0;
         idx    <= '0;
         out_q  <= '0;
      end else begin
         case (state)
            ST_SEND: begin
               if (RD_READY) begin
                  if (idx == LAST_IDX) begin
                     state <= ST_DONE;
                     idx   <= '0;
                     out_q <= '0;
                  end else begin
                     idx   <= next_idx;
                     out_q <= next_byte;
                  end
               end
            end
            default: begin
               // IDLE and DONE both accept a start, giving back-to-back words.
               if (RD_START) begin
                  state  <= ST_SEND;
                  shadow <= RD_WORD;
                  idx    <= FIRST_IDX;
                  out_q  <= RD_WORD[FIRST_LSB +: 8];
               end else begin
                  state <= ST_IDLE;
                  idx   <= '0;
                  out_q <= '0;
               end
            end
         endcase
      end
   end

   assign RD_OUT      = out_q;
   assign RD_BYTE_IDX = idx;
   assign RD_VALID    = (state == ST_SEND);
   assign RD_BUSY     = (state == ST_SEND);
   assign RD_DONE     = (state == ST_DONE);
   assign dbg_state   = state;

endmodule

// File: tb/tb_mem_byte_reader.sv
// Bench for mem_byte_reader: an LSB-first and an MSB-first instance share the same stimulus
// and are checked against a word/byte-count reference model, a byte scoreboard and a MEM loopback.
module tb_mem_byte_reader;

   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] word = '0;
   logic        ready = 1'b0;

   logic [7:0]  rd_out   [2];
   logic [1:0]  rd_idx   [2];
   logic        rd_valid [2];
   logic        rd_busy  [2];
   logic        rd_done  [2];
   logic [1:0]  dbg      [2];

   int checks = 0;
   int errors = 0;

   // reference model: per instance, the captured word, whether readout is active,
   // how many bytes have already moved, and whether the done pulse is due
   logic        m_active [2];
   logic [31:0] m_word   [2];
   int          m_k      [2];
   logic        m_done   [2];
   logic [7:0]  exp_q0[$];
   logic [7:0]  exp_q1[$];
   logic [31:0] mem_word = '0;
   int          n_xfer0 = 0;

   always #5 clk = ~clk;

   mem_byte_reader #(.NUM_BYTES(NB), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_RD(rst), .RD_START(start), .RD_WORD(word), .RD_READY(ready),
      .RD_OUT(rd_out[0]), .RD_BYTE_IDX(rd_idx[0]), .RD_VALID(rd_valid[0]),
      .RD_BUSY(rd_busy[0]), .RD_DONE(rd_done[0]), .dbg_state(dbg[0]));

   mem_byte_reader #(.NUM_BYTES(NB), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_RD(rst), .RD_START(start), .RD_WORD(word), .RD_READY(ready),
      .RD_OUT(rd_out[1]), .RD_BYTE_IDX(rd_idx[1]), .RD_VALID(rd_valid[1]),
      .RD_BUSY(rd_busy[1]), .RD_DONE(rd_done[1]), .dbg_state(dbg[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int byte_pos(input int m, input int k);
      return (m == 1) ? (NB - 1 - k) : k;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input int pos);
      return 8'((w >> (8 * pos)) & 32'hFF);
   endfunction

   task automatic model_step(input int m);
      if (rst) begin
         m_active[m] = 1'b0; m_k[m] = 0; m_done[m] = 1'b0; m_word[m] = '0;
         if (m == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (m_active[m]) begin
         m_done[m] = 1'b0;
         if (ready) begin
            if (m_k[m] == NB - 1) begin
               m_active[m] = 1'b0; m_done[m] = 1'b1;
            end else m_k[m]++;
         end
      end else begin
         m_done[m] = 1'b0;
         if (start) begin
            m_word[m] = word; m_active[m] = 1'b1; m_k[m] = 0;
            for (int k = 0; k < NB; k++) begin
               if (m == 0) exp_q0.push_back(byte_of(word, byte_pos(0, k)));
               else        exp_q1.push_back(byte_of(word, byte_pos(1, k)));
            end
         end
      end
   endtask

   task automatic sb_take(input int m);
      logic [7:0] e;
      if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
         chk($sformatf("d%0d_sb_unexpected", m), 32'(rd_out[m]), 32'hFFFF_FFFF);
      end else begin
         e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         chk($sformatf("d%0d_sb_byte", m), 32'(rd_out[m]), 32'(e));
      end
   endtask

   task automatic tick();
      logic [1:0] ei;
      for (int m = 0; m < 2; m++) begin
         if (!rst && rd_valid[m] === 1'b1 && ready) begin
            sb_take(m);
            if (m == 0) begin
               mem_word[8*rd_idx[0] +: 8] = rd_out[0];
               n_xfer0++;
            end
         end
         model_step(m);
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         ei = m_active[m] ? 2'(byte_pos(m, m_k[m])) : 2'd0;
         chk($sformatf("d%0d_valid", m), 32'(rd_valid[m]), 32'(m_active[m]));
         chk($sformatf("d%0d_busy", m),  32'(rd_busy[m]),  32'(m_active[m]));
         chk($sformatf("d%0d_done", m),  32'(rd_done[m]),  32'(m_done[m]));
         chk($sformatf("d%0d_idx", m),   32'(rd_idx[m]),   32'(ei));
         chk($sformatf("d%0d_out", m),   32'(rd_out[m]),
             m_active[m] ? 32'(byte_of(m_word[m], ei)) : 32'h0);
      end
   endtask

   task automatic run_to_done(input int limit, input bit rand_ready);
      int n = 0;
      while (rd_done[0] !== 1'b1 && n < limit) begin
         ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      chk("done_reached", 32'(rd_done[0]), 32'h1);
   endtask

   typedef struct {
      logic        rst, start, ready;
      logic [31:0] word;
      logic [7:0]  e_out0;
      logic [1:0]  e_idx0;
      logic [7:0]  e_out1;
      logic [1:0]  e_idx1;
      logic        e_valid, e_done;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        8'h00, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 32'hDDCCFFAA, 8'hAA, 2'd0, 8'hDD, 2'd3, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'hDDCCFFAA, 8'hFF, 2'd1, 8'hCC, 2'd2, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 32'hDDCCFFAA, 8'hCC, 2'd2, 8'hFF, 2'd1, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hDDCCFFAA, 8'hDD, 2'd3, 8'hAA, 2'd0, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 32'hDDCCFFAA, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hDDCCFFAA, 8'h00, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0};
      for (int m = 0; m < 2; m++) begin
         m_active[m] = 1'b0; m_word[m] = '0; m_k[m] = 0; m_done[m] = 1'b0;
      end

      // reset, then LSB-first and MSB-first readout with READY tied high
      for (int i = 0; i < 7; i++) begin
         rst = vecs[i].rst; start = vecs[i].start; ready = vecs[i].ready; word = vecs[i].word;
         tick();
         chk($sformatf("vec%0d_out0", i),  32'(rd_out[0]),   32'(vecs[i].e_out0));
         chk($sformatf("vec%0d_idx0", i),  32'(rd_idx[0]),   32'(vecs[i].e_idx0));
         chk($sformatf("vec%0d_out1", i),  32'(rd_out[1]),   32'(vecs[i].e_out1));
         chk($sformatf("vec%0d_idx1", i),  32'(rd_idx[1]),   32'(vecs[i].e_idx1));
         chk($sformatf("vec%0d_valid", i), 32'(rd_valid[0]), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_done", i),  32'(rd_done[0]),  32'(vecs[i].e_done));
      end

      // backpressure while (FF,1) is presented
      n_xfer0 = 0;
      start = 1'b1; word = 32'hDDCCFFAA; ready = 1'b1; tick();
      start = 1'b0; tick();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_out",   32'(rd_out[0]),   32'hFF);
         chk("bp_idx",   32'(rd_idx[0]),   32'h1);
         chk("bp_valid", 32'(rd_valid[0]), 32'h1);
      end
      run_to_done(20, 1'b0);
      chk("bp_xfers", 32'(n_xfer0), 32'd4);
      ready = 1'b0; tick();

      // START during SEND ignored, word change after capture ignored, restart in DONE cycle
      start = 1'b1; word = 32'hDDCCFFAA; ready = 1'b1; tick();
      word = 32'h11223344; tick();
      start = 1'b0; word = $urandom;
      run_to_done(20, 1'b0);
      start = 1'b1; word = 32'h11223344; tick();
      chk("b2b_out0", 32'(rd_out[0]), 32'h44);
      chk("b2b_out1", 32'(rd_out[1]), 32'h11);
      start = 1'b0;
      run_to_done(20, 1'b0);
      tick();

      // reset mid-transfer, then a fresh word
      start = 1'b1; word = 32'hDDCCFFAA; ready = 1'b1; tick();
      start = 1'b0; tick(); tick();
      rst = 1'b1; tick();
      chk("rst_valid", 32'(rd_valid[0]), 32'h0);
      chk("rst_out",   32'(rd_out[0]),   32'h0);
      chk("rst_idx",   32'(rd_idx[0]),   32'h0);
      chk("rst_busy",  32'(rd_busy[0]),  32'h0);
      chk("rst_done",  32'(rd_done[0]),  32'h0);
      rst = 1'b0; tick();
      chk("rst_nodone", 32'(rd_done[0]), 32'h0);
      start = 1'b1; word = 32'h0000BEEF; tick();
      chk("beef_first", 32'(rd_out[0]), 32'hEF);
      start = 1'b0;
      run_to_done(20, 1'b0);
      tick();

      // loopback into a byte-loaded MEM register with READY toggling
      mem_word = '0;
      start = 1'b1; word = 32'hDDCCFFAA; ready = 1'b0; tick();
      start = 1'b0; word = $urandom;
      run_to_done(100, 1'b1);
      chk("loopback_mem", mem_word, 32'hDDCCFFAA);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 3) == 0);
         word  = $urandom;
         ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      rst = 1'b0; start = 1'b0; ready = 1'b1;
      for (int i = 0; i < 2 * NB + 2; i++) tick();
      chk("sb_left0", 32'(exp_q0.size()), 32'd0);
      chk("sb_left1", 32'(exp_q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
